pc_stack_unit: RTL and testbench

- Parametrised program-counter unit; the next-generation PC for the core.
- Adds to the basic increment/initial-load PC: configurable width and step, absolute jump, signed relative branch, a stall enable, and a hardware call/return stack of configurable depth with error flags.
- Feeds the instruction-memory address. Control comes from the controller FSM.

---
 rtl/pc_stack_unit.sv | 93 +++++++++
 tb/tb_pc_stack_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with step/jump/relative-branch control and a LIFO return stack.
// Sticky overflow/underflow flags record misuse of the return stack until rst or init_load.
module pc_stack_unit #(
    parameter int WIDTH    = 9,
    parameter int STEP     = 4,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       init_load,
    input  logic [WIDTH-1:0]           init_pc,
    input  logic                       jump,
    input  logic [WIDTH-1:0]           jump_target,
    input  logic                       branch,
    input  logic [WIDTH-1:0]           branch_off,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           pc_out,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth,
    output logic                       stack_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
    localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH-1:0] pc_seq;
    logic [DW-1:0]    depth_dec;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             stack_empty;
    logic             do_push;

    assign pc_seq      = pc_out + STEP_W;
    assign depth_dec   = stack_depth - DW'(1);
    // Push index is only used while not full, so depth fits in AW bits.
    assign push_idx    = stack_depth[AW-1:0];
    assign pop_idx     = depth_dec[AW-1:0];
    assign stack_empty = (stack_depth == '0);
    assign stack_full  = (stack_depth == DEPTH_W);
    assign do_push     = !rst && !init_load && en && !ret && call && !stack_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out      <= RESET_W;
            stack_depth <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (init_load) begin
            pc_out      <= init_pc;
            stack_depth <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (en) begin
            if (ret) begin
                if (stack_empty) begin
                    underflow <= 1'b1;
                end else begin
                    pc_out      <= stack_mem[pop_idx];
                    stack_depth <= depth_dec;
                end
            end else if (call) begin
                if (stack_full) begin
                    overflow <= 1'b1;
                end else begin
                    pc_out      <= jump_target;
                    stack_depth <= stack_depth + DW'(1);
                end
            end else if (jump) begin
                pc_out <= jump_target;
            end else if (branch) begin
                pc_out <= pc_out + branch_off;
            end else begin
                pc_out <= pc_seq;
            end
        end
    end

    // Stack contents need no reset; only entries below stack_depth are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios plus random commands checked
// against a queue-based reference model of the PC and return stack.
module tb_pc_stack_unit;

    localparam int WIDTH = 9;
    localparam int STEP  = 4;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             init_load = 1'b0;
    logic [WIDTH-1:0] init_pc = '0;
    logic             jump = 1'b0;
    logic [WIDTH-1:0] jump_target = '0;
    logic             branch = 1'b0;
    logic [WIDTH-1:0] branch_off = '0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [WIDTH-1:0] pc_out;
    logic [2:0]       stack_depth;
    logic             stack_full;
    logic             overflow;
    logic             underflow;

    int n_compared = 0;
    int n_mismatched = 0;

    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    pc_stack_unit #(.WIDTH(WIDTH), .STEP(STEP), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .en(en), .init_load(init_load), .init_pc(init_pc),
        .jump(jump), .jump_target(jump_target), .branch(branch), .branch_off(branch_off),
        .call(call), .ret(ret), .pc_out(pc_out), .stack_depth(stack_depth),
        .stack_full(stack_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour: priority list applied with plain modular arithmetic.
    task automatic model_update();
        int soff;
        if (rst) begin
            m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
        end else if (init_load) begin
            m_pc = int'(init_pc); m_stack.delete(); m_ovf = 0; m_unf = 0;
        end else if (en) begin
            if (ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else m_unf = 1;
            end else if (call) begin
                if (m_stack.size() < DEPTH) begin
                    m_stack.push_back((m_pc + STEP) % MODV);
                    m_pc = int'(jump_target);
                end else begin
                    m_ovf = 1;
                end
            end else if (jump) begin
                m_pc = int'(jump_target);
            end else if (branch) begin
                soff = (int'(branch_off) >= MODV / 2) ? int'(branch_off) - MODV : int'(branch_off);
                m_pc = (m_pc + soff + MODV) % MODV;
            end else begin
                m_pc = (m_pc + STEP) % MODV;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("pc_out", 32'(pc_out), 32'(m_pc));
        check("stack_depth", 32'(stack_depth), 32'(m_stack.size()));
        check("stack_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic apply(input bit r, input bit il, input bit e, input bit j, input bit b,
                         input bit c, input bit rt, input int ip, input int jt, input int bo);
        rst = r; init_load = il; en = e; jump = j; branch = b; call = c; ret = rt;
        init_pc = WIDTH'(ip); jump_target = WIDTH'(jt); branch_off = WIDTH'(bo);
        tick();
    endtask

    initial begin
        // Reset and stall
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", 32'(pc_out), 32'd0);
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("inc_12", 32'(pc_out), 32'd12);
        for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stall_12", 32'(pc_out), 32'd12);

        // Load and wrap
        apply(0, 1, 1, 0, 0, 0, 0, 500, 0, 0);
        check("load_500", 32'(pc_out), 32'd500);
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_0", 32'(pc_out), 32'd0);
        apply(0, 1, 0, 0, 0, 0, 0, 500, 0, 0);
        check("load_no_en", 32'(pc_out), 32'd500);

        // Jump and branch
        apply(0, 0, 1, 1, 0, 0, 0, 0, 100, 0);
        apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 'h1F8);
        check("branch_back", 32'(pc_out), 32'd92);
        apply(0, 0, 1, 1, 1, 0, 0, 0, 200, 8);
        check("jump_wins", 32'(pc_out), 32'd200);

        // Nested call/return
        apply(0, 0, 1, 1, 0, 0, 0, 0, 16, 0);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 64, 0);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 128, 0);
        check("depth_2", 32'(stack_depth), 32'd2);
        apply(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        check("ret_68", 32'(pc_out), 32'd68);
        apply(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        check("ret_20", 32'(pc_out), 32'd20);

        // Overflow then LIFO unwind
        for (int i = 1; i <= 4; i++) apply(0, 0, 1, 0, 0, 1, 0, 0, 40 * i, 0);
        check("full", 32'(stack_full), 32'd1);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 300, 0);
        check("ovf_pc_hold", 32'(pc_out), 32'd160);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        check("unwind_last", 32'(pc_out), 32'd24);
        apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("inc_after_err", 32'(pc_out), 32'd28);

        // Underflow and precedence
        apply(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_pc_hold", 32'(pc_out), 32'd28);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 200, 0);
        apply(0, 0, 1, 0, 0, 1, 1, 0, 300, 0);
        check("ret_over_call", 32'(pc_out), 32'd32);
        check("ret_over_call_depth", 32'(stack_depth), 32'd0);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 400, 0);
        apply(1, 0, 1, 0, 0, 1, 0, 0, 300, 0);
        check("rst_mid_call_pc", 32'(pc_out), 32'd0);
        check("rst_mid_call_unf", 32'(underflow), 32'd0);

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(199) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0,
                  $urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, int'($urandom_range(MODV - 1)),
                  int'($urandom_range(MODV - 1)), int'($urandom_range(MODV - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
